// File: rtl/md_issue.sv
// Single-entry issue/hold stage in front of the multiply/divide unit.
// It launches held ops, shadows md latency, stalls decode and returns HI/LO reads.
module md_issue #(
    parameter int MD_LATENCY = 17,
    parameter int OPW        = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           abort,
    input  logic           in_valid,
    input  logic [OPW-1:0] in_op,
    input  logic [31:0]    in_a,
    input  logic [31:0]    in_b,
    output logic           stall_out,
    input  logic           md_busy,
    input  logic [31:0]    md_hl,
    output logic           md_start,
    output logic [OPW-1:0] md_op,
    output logic [31:0]    md_a,
    output logic [31:0]    md_b,
    output logic           md_clr,
    output logic           rd_valid,
    output logic [31:0]    rd_data
);

    localparam int CW = $clog2(MD_LATENCY + 1);
    localparam logic [OPW-1:0] OP_MTHI = OPW'(4);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(6);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(7);

    logic           pend_valid;
    logic [OPW-1:0] pend_op;
    logic [31:0]    pend_a, pend_b;
    logic [CW-1:0]  cnt;
    logic           busy_eff, accept, long_op, read_op;

    // cnt covers the cycle between start and md raising BUSY, so nothing can slip in.
    always_comb begin
        busy_eff  = md_busy | (cnt != '0);
        md_start  = pend_valid & ~busy_eff & ~flush & ~abort;
        stall_out = in_valid & pend_valid & ~md_start & ~flush & ~abort;
        accept    = in_valid & ~stall_out & ~flush & ~abort;
        long_op   = pend_op < OP_MTHI;
        read_op   = (pend_op == OP_MFHI) | (pend_op == OP_MFLO);
    end

    assign md_op  = pend_op;
    assign md_a   = pend_a;
    assign md_b   = pend_b;
    assign md_clr = abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_op    <= '0;
            pend_a     <= '0;
            pend_b     <= '0;
            cnt        <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_valid <= 1'b0;

            if (abort)
                cnt <= '0;
            else if (md_start && long_op)
                cnt <= CW'(MD_LATENCY);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);

            // md_start already excludes abort, so an aborted cycle never returns data
            if (md_start && read_op) begin
                rd_valid <= 1'b1;
                rd_data  <= md_hl;
            end

            // an empty entry reads as op 0 so md_op is stable between ops
            if (accept) begin
                pend_valid <= 1'b1;
                pend_op    <= in_op;
                pend_a     <= in_a;
                pend_b     <= in_b;
            end else if (md_start || flush || abort) begin
                pend_valid <= 1'b0;
                pend_op    <= '0;
                pend_a     <= '0;
                pend_b     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue with a behavioural md unit (17-cycle busy, HI/LO commit at end).
module tb_md_issue;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, MFHI = 3'd6, MFLO = 3'd7;

    logic        clk = 1'b0;
    logic        reset, flush, abort, in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic        stall_out, md_busy, md_start, md_clr, rd_valid;
    logic [31:0] md_hl, md_a, md_b, rd_data;
    logic [2:0]  md_op;

    int n_cmp = 0;
    int n_bad = 0;

    md_issue #(.MD_LATENCY(17), .OPW(3)) dut (
        .clk(clk), .reset(reset), .flush(flush), .abort(abort),
        .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .stall_out(stall_out), .md_busy(md_busy), .md_hl(md_hl),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .md_clr(md_clr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // behavioural md: results are hidden until the busy window ends
    logic [4:0]  mcnt;
    logic [31:0] hi, lo, nhi, nlo;

    assign md_busy = (mcnt != 5'd0);
    assign md_hl   = md_op[0] ? lo : hi;

    always @(posedge clk) begin
        if (reset) begin
            mcnt <= 5'd0; hi <= 32'd0; lo <= 32'd0; nhi <= 32'd0; nlo <= 32'd0;
        end else if (md_clr) begin
            mcnt <= 5'd0;
        end else if (md_start) begin
            case (md_op)
                MULT:  begin {nhi, nlo} <= {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b}; mcnt <= 5'd17; end
                MULTU: begin {nhi, nlo} <= {32'd0, md_a} * {32'd0, md_b}; mcnt <= 5'd17; end
                DIV:   begin
                    nlo  <= (md_b == 0) ? 32'd0 : $signed(md_a) / $signed(md_b);
                    nhi  <= (md_b == 0) ? 32'd0 : $signed(md_a) % $signed(md_b);
                    mcnt <= 5'd17;
                end
                DIVU:  begin
                    nlo  <= (md_b == 0) ? 32'd0 : md_a / md_b;
                    nhi  <= (md_b == 0) ? 32'd0 : md_a % md_b;
                    mcnt <= 5'd17;
                end
                MTHI:    hi <= md_a;
                MTLO:    lo <= md_a;
                default: ;
            endcase
        end else if (mcnt != 5'd0) begin
            mcnt <= mcnt - 5'd1;
            if (mcnt == 5'd1) begin
                hi <= nhi;
                lo <= nlo;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic ab);
        in_valid = v; in_op = op; in_a = a; in_b = b; flush = fl; abort = ab;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    int stalls, starts;

    initial begin
        reset = 1'b1;
        idle();
        do_reset();

        // reset state
        mid();
        chk("rst_start",  32'(md_start),  32'd0);
        chk("rst_stall",  32'(stall_out), 32'd0);
        chk("rst_rdv",    32'(rd_valid),  32'd0);
        chk("rst_rdd",    rd_data,        32'd0);
        chk("rst_op",     32'(md_op),     32'd0);
        chk("rst_a",      md_a,           32'd0);
        chk("rst_b",      md_b,           32'd0);
        chk("rst_clr",    32'(md_clr),    32'd0);
        nxt();

        // mult -2*3, then mfhi, then mflo held by stall
        drive(1'b1, MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        mid(); chk("s1_c0_start", 32'(md_start), 32'd0); nxt();
        drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        mid();
        chk("s1_c1_start", 32'(md_start), 32'd1);
        chk("s1_c1_a", md_a, 32'hFFFF_FFFE);
        chk("s1_c1_stall", 32'(stall_out), 32'd0);
        nxt();
        stalls = 0; starts = 0;
        for (int c = 2; c <= 18; c++) begin
            drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
            mid(); stalls += 32'(stall_out); starts += 32'(md_start); nxt();
        end
        chk("s1_stall_cycles", 32'(stalls), 32'd17);
        chk("s1_no_start_busy", 32'(starts), 32'd0);
        mid();
        chk("s1_c19_start", 32'(md_start), 32'd1);
        chk("s1_c19_stall", 32'(stall_out), 32'd0);
        chk("s1_c19_op", 32'(md_op), 32'(MFHI));
        nxt();
        idle();
        mid();
        chk("s1_c20_start", 32'(md_start), 32'd1);
        chk("s1_c20_rdv", 32'(rd_valid), 32'd1);
        chk("s1_mfhi", rd_data, 32'hFFFF_FFFF);
        nxt();
        mid();
        chk("s1_c21_rdv", 32'(rd_valid), 32'd1);
        chk("s1_mflo", rd_data, 32'hFFFF_FFFA);
        nxt();
        mid(); chk("s1_c22_rdv", 32'(rd_valid), 32'd0); nxt();

        // mthi then mfhi back-to-back
        do_reset();
        drive(1'b1, MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        mid(); nxt();
        drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        mid();
        chk("s2_c1_start", 32'(md_start), 32'd1);
        chk("s2_c1_stall", 32'(stall_out), 32'd0);
        nxt();
        idle();
        mid();
        chk("s2_c2_start", 32'(md_start), 32'd1);
        chk("s2_c2_rdv", 32'(rd_valid), 32'd0);
        nxt();
        mid();
        chk("s2_c3_rdv", 32'(rd_valid), 32'd1);
        chk("s2_mfhi", rd_data, 32'h1234_5678);
        nxt();

        // divu 7/2 then mflo, mfhi
        do_reset();
        drive(1'b1, DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        mid(); nxt();
        drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        mid(); chk("s3_c1_start", 32'(md_start), 32'd1); nxt();
        idle();
        starts = 0;
        for (int c = 2; c <= 18; c++) begin
            mid(); starts += 32'(md_start); nxt();
        end
        chk("s3_no_early_start", 32'(starts), 32'd0);
        mid();
        chk("s3_c19_start", 32'(md_start), 32'd1);
        chk("s3_c19_op", 32'(md_op), 32'(MFLO));
        nxt();
        drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        mid();
        chk("s3_c20_rdv", 32'(rd_valid), 32'd1);
        chk("s3_quot", rd_data, 32'd3);
        nxt();
        idle();
        mid(); chk("s3_c21_start", 32'(md_start), 32'd1); nxt();
        mid();
        chk("s3_c22_rdv", 32'(rd_valid), 32'd1);
        chk("s3_rem", rd_data, 32'd1);
        nxt();

        // pending mtlo flushed at cycle 5 while mult in flight
        do_reset();
        drive(1'b1, MULT, 32'h0001_0000, 32'h0001_0003, 1'b0, 1'b0);
        mid(); nxt();
        drive(1'b1, MTLO, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0);
        mid(); chk("s4_c1_start", 32'(md_start), 32'd1); nxt();
        idle();
        for (int c = 2; c <= 4; c++) begin
            mid(); nxt();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        mid();
        chk("s4_c5_start", 32'(md_start), 32'd0);
        chk("s4_c5_stall", 32'(stall_out), 32'd0);
        nxt();
        idle();
        starts = 0;
        for (int c = 6; c <= 19; c++) begin
            mid(); starts += 32'(md_start); nxt();
        end
        chk("s4_no_extra_start", 32'(starts), 32'd0);
        drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        mid(); nxt();
        idle();
        mid(); chk("s4_c21_start", 32'(md_start), 32'd1); nxt();
        mid();
        chk("s4_c22_rdv", 32'(rd_valid), 32'd1);
        chk("s4_mflo", rd_data, 32'h0003_0000);
        nxt();

        // abort at cycle 8 of a div
        do_reset();
        drive(1'b1, DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        mid(); nxt();
        idle();
        for (int c = 1; c <= 7; c++) begin
            mid(); nxt();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        mid();
        chk("s5_c8_clr", 32'(md_clr), 32'd1);
        chk("s5_c8_start", 32'(md_start), 32'd0);
        nxt();
        drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        mid();
        chk("s5_c9_clr", 32'(md_clr), 32'd0);
        chk("s5_c9_stall", 32'(stall_out), 32'd0);
        nxt();
        idle();
        mid();
        chk("s5_c10_start", 32'(md_start), 32'd1);
        chk("s5_c10_op", 32'(md_op), 32'(MFHI));
        nxt();
        mid();
        chk("s5_c11_rdv", 32'(rd_valid), 32'd1);
        chk("s5_mfhi", rd_data, 32'd0);
        nxt();

        // in_valid together with flush, pend empty
        do_reset();
        drive(1'b1, MTHI, 32'h0000_0055, 32'd0, 1'b1, 1'b0);
        mid();
        chk("s6_c0_stall", 32'(stall_out), 32'd0);
        chk("s6_c0_start", 32'(md_start), 32'd0);
        nxt();
        idle();
        mid();
        chk("s6_c1_start", 32'(md_start), 32'd0);
        chk("s6_c1_a", md_a, 32'd0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md_issue.md
Name: md_issue

Overview:
- Issue/hold stage directly upstream of the multiply/divide unit (md) in the E stage.
- Accepts one md-class instruction (mult, multu, div, divu, mthi, mtlo, mfhi, mflo) per cycle from the D/E pipeline register into a single-entry holding register.
- Launches held operations with a one-cycle start pulse, keeps a shadow latency counter so new operations cannot race a BUSY that has not yet risen, stalls decode, and returns the mfhi/mflo read data as a registered, valid-tagged result.

Parameters:
- MD_LATENCY, 17: cycles md stays busy after a mult/multu/div/divu start; must equal md's internal count.
- OPW, 3: md operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  drop the held (not yet issued) operation.
- abort  in  1  flush plus cancel in-flight md work; drives md_clr.
- in_valid  in  1  md-class instruction present from decode.
- in_op  in  3  op code: mult 000, multu 001, div 010, divu 011, mthi 100, mtlo 101, mfhi 110, mflo 111.
- in_a  in  32  rs operand.
- in_b  in  32  rt operand.
- stall_out  out  1  decode must hold the instruction.
- md_busy  in  1  md BUSY.
- md_hl  in  32  md HL read port.
- md_start  out  1  start pulse to md.
- md_op  out  3  op to md.
- md_a  out  32  operand A to md.
- md_b  out  32  operand B to md.
- md_clr  out  1  clear to md.
- rd_valid  out  1  one-cycle pulse: rd_data holds the mfhi/mflo result.
- rd_data  out  32  registered HI/LO value.

Behaviour:
- Reset: pend_valid=0, pend_op/a/b=0, cnt=0, rd_valid=0, rd_data=0. All outputs read 0 the cycle after reset.
- busy_eff = md_busy | (cnt != 0).
- Issue, combinational:
  - md_start = pend_valid & ~busy_eff & ~flush & ~abort.
  - md_op/md_a/md_b = pend registers.
  - When md_start=0, md_op is still driven from pend_op (pend_op=0 when empty), so HL reads stay stable.
- Accept:
  - Capture occurs when in_valid & ~stall_out & ~flush & ~abort, into pend at the clock edge.
  - stall_out = in_valid & pend_valid & ~md_start. Accept and issue in the same cycle is allowed (back-to-back).
- On an issue edge:
  - pend_valid clears unless refilled the same cycle.
  - mult/multu/div/divu: cnt <= MD_LATENCY.
  - mthi/mtlo: cnt unchanged (stays 0).
  - mfhi/mflo: rd_data <= md_hl, rd_valid <= 1 the next cycle.
- Otherwise cnt decrements when nonzero. rd_valid drops after one cycle.
- Any op, including mthi/mtlo/mfhi/mflo, waits while busy_eff. HI/LO are therefore never read or overwritten mid-computation.
- Latency, mult accepted in cycle 0:
  - start in cycle 1.
  - busy_eff high cycles 2..18.
  - a following mfhi issues in cycle 19; rd_valid is high in cycle 20.
- flush: pend_valid <= 0. An in-flight md computation and cnt continue. stall_out is forced 0 that cycle.
- abort: md_clr=1 combinationally. cnt <= 0, pend_valid <= 0, rd_valid <= 0.
- flush/abort with in_valid in the same cycle: the input is discarded, not captured.
- Division by zero: passed to md unchanged; the result is md-defined and has no special handling here.
- Reset mid-operation: all state clears. md_clr is not asserted; md has its own reset.

Test Plan:
- Reset, then mult a=0xFFFFFFFE b=3 in cycle 0, mfhi in cycle 1 (stall_out=1 cycles 2..18): md_start in cycles 1 and 19 only; rd_valid in cycle 20 with rd_data=0xFFFFFFFF. Follow with mflo: rd_data=0xFFFFFFFA.
- mthi 0x12345678 then mfhi back-to-back: no stall, md_start in two consecutive cycles, rd_data=0x12345678 two cycles after the mfhi accept.
- divu 7/2 then immediate mflo: mflo issues exactly MD_LATENCY+1 cycles after the divu start, rd_data=3. mfhi then gives 1.
- Pending mtlo with an in-flight mult plus flush at cycle 5: pend dropped, no extra md_start. mult completes; mflo returns the mult low word.
- abort at cycle 8 of a div: md_clr=1 for one cycle, cnt=0, stall_out=0 next cycle. A following mfhi issues immediately and returns 0.
- Simultaneous in_valid and flush with pend empty: nothing captured, md_start stays 0, stall_out=0.
